cdb_arbiter_rr: RTL and testbench
=================================

CDB_ARBITER_RR -- requirements
Module: cdb_arbiter_rr

Interface
REQ-001 Parameter N_FU, default 4, SHALL set the number of requesters: index 0 ALU, 1 MUL, 2 MEM, 3 BR.
REQ-002 Parameter DEPTH, default 2, SHALL set the per-requester completion buffer depth in entries.
REQ-003 Port clock, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port fu_valid, input, N_FU bits: per-requester completion request.
REQ-006 Port fu_ready, output, N_FU bits: per-requester buffer can accept.
REQ-007 Port fu_value, input, N_FU x XLEN: result value.
REQ-008 Port fu_prf_idx, input, N_FU x PRF_LEN: destination physical register.
REQ-009 Port fu_rob_idx, input, N_FU x ROB_LEN: ROB tag.
REQ-010 Port fu_PC, input, N_FU x XLEN: instruction PC.
REQ-011 Port squash, input, 1 bit: mispredict flush.
REQ-012 Port cdb_valid, output, 1 bit: broadcast valid.
REQ-013 Port cdb_value, output, XLEN: broadcast value.
REQ-014 Port cdb_prf_idx, output, PRF_LEN: broadcast destination physical register.
REQ-015 Port cdb_rob_idx, output, ROB_LEN: broadcast ROB tag.
REQ-016 Port cdb_PC, output, XLEN: broadcast PC.
REQ-017 Port cdb_src, output, log2(N_FU): index of the granted requester.

Function
REQ-018 A transfer on requester i SHALL occur at a rising edge where fu_valid[i] and fu_ready[i] are both 1 and squash is 0.
REQ-019 fu_ready[i] SHALL be 1 iff buffer i holds fewer than DEPTH entries, derived from registered count only, with no combinational path from fu_valid.
REQ-020 Each buffer SHALL be a FIFO; a push and a pop in the same cycle on a full buffer SHALL NOT be possible, because ready was 0.
REQ-021 Each cycle the arbiter SHALL grant exactly one non-empty buffer, searching round-robin starting at rr_ptr and wrapping from N_FU-1 to 0.
REQ-022 On a grant to buffer g, rr_ptr SHALL become (g+1) mod N_FU; with no grant, rr_ptr SHALL hold.
REQ-023 On a grant, that buffer's head SHALL be popped and its payload registered onto the cdb_* outputs with cdb_valid=1 and cdb_src=g at the same edge.
REQ-024 With no buffer non-empty, cdb_valid SHALL be 0 and cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC and cdb_src SHALL be 0.
REQ-025 Latency SHALL be as follows: an entry pushed at edge t into an empty buffer with rr_ptr pointing to it SHALL appear on cdb at edge t+1.
REQ-026 Any requester with a non-empty buffer SHALL be granted within N_FU cycles.
REQ-027 With squash=1 at an edge, all buffers SHALL empty, no push SHALL occur, cdb_valid SHALL be 0 with a zero payload, and rr_ptr SHALL hold.
REQ-028 Occupancy counters SHALL be clog2(DEPTH+1) bits and pointers clog2(DEPTH) bits, wrapping modulo DEPTH.

Reset
REQ-029 On reset at an edge, all buffers SHALL empty, rr_ptr SHALL be 0, cdb_valid and all cdb_* outputs SHALL be 0, and fu_ready SHALL be all 1 after that edge.
REQ-030 Reset SHALL take priority over squash and over any push or pop in the same cycle.

Structure
REQ-031 XLEN (32), PRF_LEN (6), ROB_LEN (5) and a cdb_packet_t typedef {value, prf_idx, rob_idx, PC} SHALL live in the shared package.
REQ-032 The per-requester buffer SHALL be one sub-module, cdb_fifo, instantiated N_FU times; the arbitration and output register SHALL stay in cdb_arbiter_rr.

Verification
REQ-033 Reset, then ALU push {value=0x11, rob=3} -> next edge: cdb_valid=1, cdb_value=0x11, cdb_rob_idx=3, cdb_src=0.
REQ-034 All four push in one cycle with rr_ptr=0 -> four consecutive broadcasts with cdb_src 0,1,2,3, then cdb_valid=0.
REQ-035 MUL pushes 3 times back-to-back with no pops blocked only by arbitration; DEPTH=2 -> fu_ready[1]=0 when 2 entries are held, no entry lost, FIFO order kept.
REQ-036 Buffers MEM and BR each hold 2 entries, squash=1 for one cycle -> next edge: cdb_valid=0, fu_ready=4'b1111, no later broadcast of the flushed entries.
REQ-037 Continuous ALU requests plus a single BR request -> BR is broadcast within 4 cycles (starvation bound).
REQ-038 Reset asserted while all buffers are full -> after the edge: outputs 0, rr_ptr=0, first post-reset grant goes to index 0 when all requesters push.

Source files
------------

// File: rtl/cdb_arbiter_rr_pkg.sv
// Shared widths and the broadcast packet carried from the functional units to the CDB.
package cdb_arbiter_rr_pkg;

  localparam int XLEN    = 32;
  localparam int PRF_LEN = 6;
  localparam int ROB_LEN = 5;

  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    PC;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-requester completion buffer: a small circular FIFO with a registered occupancy count.
module cdb_fifo
  import cdb_arbiter_rr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  cdb_packet_t push_data,
  input  logic        pop,
  output cdb_packet_t head,
  output logic        ready,
  output logic        not_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_packet_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head      = mem[rd_ptr];
  assign ready     = (count < CNT_W'(DEPTH));
  assign not_empty = (count != '0);

endmodule

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter that drains per-FU completion buffers onto a single registered CDB.
// Handshake: a transfer on FU i happens at a rising edge with fu_valid[i] && fu_ready[i] && !squash;
// fu_ready depends only on registered occupancy, never combinationally on fu_valid.
module cdb_arbiter_rr
  import cdb_arbiter_rr_pkg::*;
#(
  parameter int N_FU  = 4,
  parameter int DEPTH = 2,
  localparam int SRC_W = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_FU-1:0]         fu_valid,
  output logic [N_FU-1:0]         fu_ready,
  input  logic [N_FU*XLEN-1:0]    fu_value,
  input  logic [N_FU*PRF_LEN-1:0] fu_prf_idx,
  input  logic [N_FU*ROB_LEN-1:0] fu_rob_idx,
  input  logic [N_FU*XLEN-1:0]    fu_PC,
  input  logic                    squash,
  output logic                    cdb_valid,
  output logic [XLEN-1:0]         cdb_value,
  output logic [PRF_LEN-1:0]      cdb_prf_idx,
  output logic [ROB_LEN-1:0]      cdb_rob_idx,
  output logic [XLEN-1:0]         cdb_PC,
  output logic [SRC_W-1:0]        cdb_src
);

  cdb_packet_t      push_data [N_FU];
  cdb_packet_t      head      [N_FU];
  logic [N_FU-1:0]  push;
  logic [N_FU-1:0]  pop;
  logic [N_FU-1:0]  not_empty;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_valid;
  cdb_packet_t      cdb_q;

  for (genvar i = 0; i < N_FU; i++) begin : g_fifo
    assign push_data[i] = '{value:   fu_value[i*XLEN +: XLEN],
                            prf_idx: fu_prf_idx[i*PRF_LEN +: PRF_LEN],
                            rob_idx: fu_rob_idx[i*ROB_LEN +: ROB_LEN],
                            PC:      fu_PC[i*XLEN +: XLEN]};
    assign push[i] = fu_valid[i] & fu_ready[i] & ~squash;
    assign pop[i]  = grant_valid & ~squash & (grant_idx == SRC_W'(i));

    cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (squash),
      .push      (push[i]),
      .push_data (push_data[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .ready     (fu_ready[i]),
      .not_empty (not_empty[i])
    );
  end

  // First non-empty buffer at or after rr_ptr, wrapping past N_FU-1.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < N_FU; k++) begin
      cand = (int'(rr_ptr) + k) % N_FU;
      if (!grant_valid && not_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(cand);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
      cdb_src   <= '0;
    end else if (squash || !grant_valid) begin
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= 1'b1;
      cdb_q     <= head[grant_idx];
      cdb_src   <= grant_idx;
      rr_ptr    <= (grant_idx == SRC_W'(N_FU - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  assign cdb_value   = cdb_q.value;
  assign cdb_prf_idx = cdb_q.prf_idx;
  assign cdb_rob_idx = cdb_q.rob_idx;
  assign cdb_PC      = cdb_q.PC;

endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// Bench for cdb_arbiter_rr: queue-based model checked every cycle plus directed literal checks.
module tb_cdb_arbiter_rr;
  import cdb_arbiter_rr_pkg::*;

  localparam int N_FU  = 4;
  localparam int DEPTH = 2;
  localparam int SRC_W = 2;
  localparam int PKT_W = XLEN + PRF_LEN + ROB_LEN + XLEN;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    squash = 1'b0;
  logic [N_FU-1:0]         fu_valid = '0;
  logic [N_FU-1:0]         fu_ready;
  logic [N_FU*XLEN-1:0]    fu_value = '0;
  logic [N_FU*PRF_LEN-1:0] fu_prf_idx = '0;
  logic [N_FU*ROB_LEN-1:0] fu_rob_idx = '0;
  logic [N_FU*XLEN-1:0]    fu_PC = '0;
  logic                    cdb_valid;
  logic [XLEN-1:0]         cdb_value;
  logic [PRF_LEN-1:0]      cdb_prf_idx;
  logic [ROB_LEN-1:0]      cdb_rob_idx;
  logic [XLEN-1:0]         cdb_PC;
  logic [SRC_W-1:0]        cdb_src;

  int compared   = 0;
  int mismatched = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  cdb_arbiter_rr #(.N_FU(N_FU), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .fu_valid    (fu_valid),
    .fu_ready    (fu_ready),
    .fu_value    (fu_value),
    .fu_prf_idx  (fu_prf_idx),
    .fu_rob_idx  (fu_rob_idx),
    .fu_PC       (fu_PC),
    .squash      (squash),
    .cdb_valid   (cdb_valid),
    .cdb_value   (cdb_value),
    .cdb_prf_idx (cdb_prf_idx),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_PC      (cdb_PC),
    .cdb_src     (cdb_src)
  );

  // ---------------- model / scoreboard ----------------
  logic [PKT_W-1:0] exp_q [N_FU][$];
  bit               m_rdy [N_FU];
  int               m_rr = 0;
  int               m_c = 0;
  bit               model_ok = 1'b0;
  logic             m_valid = 1'b0;
  logic [PKT_W-1:0] m_pkt = '0;
  int               m_src = 0;
  logic [N_FU-1:0]  m_ready;

  function automatic logic [PKT_W-1:0] pkt_of(input int k);
    return {fu_value[k*XLEN +: XLEN], fu_prf_idx[k*PRF_LEN +: PRF_LEN],
            fu_rob_idx[k*ROB_LEN +: ROB_LEN], fu_PC[k*XLEN +: XLEN]};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_FU; k++) exp_q[k].delete();
      m_rr = 0; m_valid = 1'b0; m_pkt = '0; m_src = 0; model_ok = 1'b1;
    end else if (squash) begin
      for (int k = 0; k < N_FU; k++) exp_q[k].delete();
      m_valid = 1'b0; m_pkt = '0; m_src = 0;
    end else begin
      for (int k = 0; k < N_FU; k++) m_rdy[k] = (exp_q[k].size() < DEPTH);
      m_valid = 1'b0; m_pkt = '0; m_src = 0;
      for (int k = 0; k < N_FU; k++) begin
        m_c = (m_rr + k) % N_FU;
        if (!m_valid && exp_q[m_c].size() > 0) begin
          m_valid = 1'b1;
          m_src   = m_c;
          m_pkt   = exp_q[m_c].pop_front();
        end
      end
      if (m_valid) m_rr = (m_src + 1) % N_FU;
      for (int k = 0; k < N_FU; k++)
        if (fu_valid[k] && m_rdy[k]) exp_q[k].push_back(pkt_of(k));
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      for (int k = 0; k < N_FU; k++) m_ready[k] = (exp_q[k].size() < DEPTH);
      compared++;
      if (cdb_valid !== m_valid || cdb_src !== SRC_W'(m_src) ||
          {cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC} !== m_pkt || fu_ready !== m_ready) begin
        mismatched++;
        $display("FAIL cycle_compare t=%0t: got valid=%b src=%0d pkt=%h ready=%b, expected valid=%b src=%0d pkt=%h ready=%b",
                 $time, cdb_valid, cdb_src, {cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC}, fu_ready,
                 m_valid, m_src, m_pkt, m_ready);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [XLEN-1:0] v, input logic [PRF_LEN-1:0] prf,
                         input logic [ROB_LEN-1:0] rob, input logic [XLEN-1:0] pc);
    fu_valid[i] = 1'b1;
    fu_value[i*XLEN +: XLEN]         = v;
    fu_prf_idx[i*PRF_LEN +: PRF_LEN] = prf;
    fu_rob_idx[i*ROB_LEN +: ROB_LEN] = rob;
    fu_PC[i*XLEN +: XLEN]            = pc;
  endtask

  task automatic set_all(input logic [XLEN-1:0] base);
    for (int i = 0; i < N_FU; i++)
      set_req(i, base + XLEN'(i), PRF_LEN'(i + 8), ROB_LEN'(i + 16), 32'h1000 + XLEN'(i * 4));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit seen;

    tick(); tick();
    reset = 1'b0;
    check("reset_valid", cdb_valid, 0);
    check("reset_ready", fu_ready, 4'hf);
    check("reset_src", cdb_src, 0);
    check("reset_value", cdb_value, 0);

    // Single ALU completion appears one edge after its push.
    set_req(0, 32'h11, 6'd7, 5'd3, 32'h100);
    tick();
    fu_valid = '0;
    check("alu_push_edge_valid", cdb_valid, 0);
    tick();
    check("alu_valid", cdb_valid, 1);
    check("alu_value", cdb_value, 32'h11);
    check("alu_rob", cdb_rob_idx, 3);
    check("alu_src", cdb_src, 0);
    tick();
    check("alu_idle", cdb_valid, 0);

    // All four push together from rr_ptr=0.
    reset = 1'b1; tick(); reset = 1'b0;
    set_all(32'h20);
    tick();
    fu_valid = '0;
    for (int i = 0; i < N_FU; i++) begin
      tick();
      check("burst_valid", cdb_valid, 1);
      check("burst_src", cdb_src, i);
      check("burst_value", cdb_value, 32'h20 + i);
    end
    tick();
    check("burst_done", cdb_valid, 0);

    // MUL back-pressure: fills to DEPTH while others hold the arbiter.
    set_all(32'h30);
    set_req(1, 32'h40, 6'd1, 5'd1, 32'h200);
    tick();
    fu_valid = '0;
    set_req(1, 32'h41, 6'd2, 5'd2, 32'h204);
    tick();
    check("mul_full_ready", fu_ready, 4'b1101);
    check("mul_full_src", cdb_src, 0);
    set_req(1, 32'h42, 6'd3, 5'd3, 32'h208);
    tick();
    check("mul_first_value", cdb_value, 32'h40);
    check("mul_first_src", cdb_src, 1);
    check("mul_ready_again", fu_ready[1], 1);
    tick();
    fu_valid = '0;
    check("mul_wait_src_mem", cdb_src, 2);
    tick();
    check("mul_wait_src_br", cdb_src, 3);
    tick();
    check("mul_second_value", cdb_value, 32'h41);
    tick();
    check("mul_third_value", cdb_value, 32'h42);
    tick();
    check("mul_drained", cdb_valid, 0);

    // Squash with MEM and BR holding two entries each.
    reset = 1'b1; tick(); reset = 1'b0;
    set_all(32'h50);
    tick();
    fu_valid = '0;
    set_req(2, 32'h62, 6'd4, 5'd4, 32'h300);
    set_req(3, 32'h63, 6'd5, 5'd5, 32'h304);
    tick();
    fu_valid = '0;
    check("pre_squash_ready", fu_ready, 4'b0011);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    check("squash_valid", cdb_valid, 0);
    check("squash_ready", fu_ready, 4'hf);
    check("squash_value", cdb_value, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_squash_idle", cdb_valid, 0);
    end

    // Continuous ALU traffic must not starve a single BR request.
    set_req(0, 32'h70, 6'd9, 5'd9, 32'h400);
    set_req(3, 32'h7b, 6'd10, 5'd10, 32'h404);
    tick();
    fu_valid[3] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < N_FU; i++) begin
      tick();
      if (cdb_valid && cdb_src == 2'd3) begin
        seen = 1'b1;
        check("br_value", cdb_value, 32'h7b);
        break;
      end
    end
    check("br_within_bound", seen, 1);
    fu_valid = '0;
    repeat (4) tick();

    // Reset while saturated.
    set_all(32'h80);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sat_reset_valid", cdb_valid, 0);
    check("sat_reset_value", cdb_value, 0);
    check("sat_reset_src", cdb_src, 0);
    check("sat_reset_ready", fu_ready, 4'hf);
    set_all(32'h90);
    tick();
    fu_valid = '0;
    tick();
    check("post_reset_grant_valid", cdb_valid, 1);
    check("post_reset_grant_src", cdb_src, 0);
    check("post_reset_grant_value", cdb_value, 32'h90);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
